// File: rtl/mipi_pkg.sv
// -----------------------------------------------------------------------------
// mipi_pkg
// Shared constants for the MIPI D-PHY byte aligner:
//   - SYNC_BYTE        : HS sync pattern (bit 0 is the first bit on the line)
//   - TOP_*            : top-level alignment FSM encoding
//   - LANE_*           : per-lane hunt/lock FSM encoding
//   - find_sync()      : lowest-offset sync search over a 16-bit lane window
// -----------------------------------------------------------------------------
package mipi_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hB8;

   // Top FSM: waiting for a first lock, collecting skewed lanes, streaming,
   // and latched error until the burst ends.
   localparam logic [1:0] TOP_IDLE = 2'd0;
   localparam logic [1:0] TOP_WAIT = 2'd1;
   localparam logic [1:0] TOP_RUN  = 2'd2;
   localparam logic [1:0] TOP_ERR  = 2'd3;

   localparam logic [0:0] LANE_HUNT   = 1'b0;
   localparam logic [0:0] LANE_LOCKED = 1'b1;

   // Returns {hit, offset}. The loop walks from the highest offset down so
   // the lowest matching offset is the one left in the result.
   function automatic logic [3:0] find_sync(input logic [15:0] w,
                                            input logic [7:0]  sync);
      logic [3:0] res;
      res = 4'd0;
      for (int k = 7; k >= 0; k--) begin
         if (w[k +: 8] == sync) begin
            res = {1'b1, 3'(k)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mipi_fifo_chk.sv
// -----------------------------------------------------------------------------
// mipi_fifo_chk
// Assertion-only checker bound to one lane FIFO.
// Ports:
//   gclk, rst   clock and synchronous active-high reset
//   push, pop   accepted write / accepted read this cycle
//   full, empty FIFO status flags
//   pop_req     common pop request from the top level
// -----------------------------------------------------------------------------
module mipi_fifo_chk (
   input logic gclk,
   input logic rst,
   input logic push,
   input logic pop,
   input logic full,
   input logic empty,
   input logic pop_req
);

   // Overflow would silently drop a byte; underflow would emit a stale one.
   always @(posedge gclk) begin
      if (!rst) begin
         assert (!(push && full && !pop));
         assert (!(pop_req && empty));
      end
   end

endmodule

// File: rtl/mipi_lane_aligner.sv
// -----------------------------------------------------------------------------
// mipi_lane_aligner
// One D-PHY data lane: hunts for the HS sync byte at any of 8 bit offsets,
// locks that offset and pushes aligned payload bytes into a small FIFO that
// absorbs lock-time skew between lanes.
// Ports:
//   gclk        byte-rate clock
//   rst         synchronous active-high reset
//   hs_active   HS burst in progress; low returns the lane to HUNT
//   force_hunt  top-level abort (skew timeout / error hold)
//   pop         common pop from the top level
//   din         unaligned deserialized byte, bit 0 earliest
//   hit         sync seen this cycle while hunting (before abort gating)
//   locked      offset is locked
//   fifo_empty  FIFO holds no byte
//   data        FIFO head byte
// -----------------------------------------------------------------------------
module mipi_lane_aligner
   import mipi_pkg::*;
#(
   parameter logic [7:0] SYNC  = SYNC_BYTE,
   parameter int         DEPTH = 4
) (
   input  logic       gclk,
   input  logic       rst,
   input  logic       hs_active,
   input  logic       force_hunt,
   input  logic       pop,
   input  logic [7:0] din,
   output logic       hit,
   output logic       locked,
   output logic       fifo_empty,
   output logic [7:0] data
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [7:0]    prev_r;
   logic [15:0]   w_s;
   logic [3:0]    srch_s;
   logic [2:0]    off_r;
   logic [0:0]    state_r;
   logic [7:0]    aligned_s;
   logic [7:0]    mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] cnt_r;
   logic          flush_s;
   logic          push_s;
   logic          do_pop_s;
   logic          full_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + 1'b1;
   endfunction

   // Older byte sits in the low half, so offset k selects bits k..k+7 in
   // line order.
   assign w_s       = {din, prev_r};
   assign srch_s    = find_sync(w_s, SYNC);
   assign aligned_s = w_s[off_r +: 8];

   assign flush_s    = !hs_active || force_hunt;
   assign hit        = (state_r == LANE_HUNT) && hs_active && srch_s[3];
   assign push_s     = (state_r == LANE_LOCKED) && !flush_s;
   assign full_s     = (cnt_r == CW'(DEPTH));
   assign fifo_empty = (cnt_r == {CW{1'b0}});
   assign do_pop_s   = pop && !fifo_empty && !flush_s;
   assign locked     = (state_r == LANE_LOCKED);
   assign data       = mem_r[rd_ptr_r];

   // Previous-byte register forming the 16-bit search window.
   always_ff @(posedge gclk) begin
      if (rst) begin
         prev_r <= 8'h00;
      end else begin
         prev_r <= din;
      end
   end

   // Lane FSM and offset latch; the sync byte itself is never pushed.
   always_ff @(posedge gclk) begin
      if (rst) begin
         state_r <= LANE_HUNT;
         off_r   <= 3'd0;
      end else if (flush_s) begin
         state_r <= LANE_HUNT;
         off_r   <= off_r;
      end else begin
         case (state_r)
            LANE_HUNT: begin
               if (hit) begin
                  state_r <= LANE_LOCKED;
                  off_r   <= srch_s[2:0];
               end else begin
                  state_r <= LANE_HUNT;
                  off_r   <= off_r;
               end
            end
            LANE_LOCKED: begin
               state_r <= LANE_LOCKED;
               off_r   <= off_r;
            end
            default: begin
               state_r <= LANE_HUNT;
               off_r   <= 3'd0;
            end
         endcase
      end
   end

   // FIFO storage; contents need no reset because occupancy gates reads.
   always_ff @(posedge gclk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= aligned_s;
      end
   end

   // FIFO pointers and occupancy; flushing discards undrained bytes.
   always_ff @(posedge gclk) begin
      if (rst || flush_s) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         cnt_r    <= {CW{1'b0}};
      end else begin
         wr_ptr_r <= push_s   ? ptr_inc(wr_ptr_r) : wr_ptr_r;
         rd_ptr_r <= do_pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
         case ({push_s, do_pop_s})
            2'b10:   cnt_r <= cnt_r + 1'b1;
            2'b01:   cnt_r <= cnt_r - 1'b1;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   mipi_fifo_chk u_chk (
      .gclk    (gclk),
      .rst     (rst),
      .push    (push_s),
      .pop     (do_pop_s),
      .full    (full_s),
      .empty   (fifo_empty),
      .pop_req (pop)
   );

endmodule

// File: rtl/mipi_byte_aligner.sv
// -----------------------------------------------------------------------------
// mipi_byte_aligner
// Aligns and deskews the per-lane bytes of a MIPI D-PHY receiver so the packet
// layer sees one lane-coherent word per cycle.
// Ports:
//   gclk         byte-rate fabric clock (only clock)
//   rst          synchronous active-high reset
//   hs_active    HS burst in progress
//   din          LANES unaligned bytes, lane i at din[i*8 +: 8]
//   dout         aligned, deskewed word, same packing
//   dout_valid   dout holds a valid word
//   lane_locked  per-lane lock flags
//   sync_err     one-cycle pulse when lanes fail to lock within MAX_SKEW
// -----------------------------------------------------------------------------
module mipi_byte_aligner
   import mipi_pkg::*;
#(
   parameter int         LANES     = 4,
   parameter logic [7:0] SYNC_BYTE = mipi_pkg::SYNC_BYTE,
   parameter int         MAX_SKEW  = 3
) (
   input  logic               gclk,
   input  logic               rst,
   input  logic               hs_active,
   input  logic [LANES*8-1:0] din,
   output logic [LANES*8-1:0] dout,
   output logic               dout_valid,
   output logic [LANES-1:0]   lane_locked,
   output logic               sync_err
);

   localparam int DEPTH = MAX_SKEW + 1;
   localparam int CW    = (MAX_SKEW > 1) ? $clog2(MAX_SKEW) : 1;

   logic [LANES-1:0]   hit_s;
   logic [LANES-1:0]   locked_s;
   logic [LANES-1:0]   empty_s;
   logic [LANES*8-1:0] word_s;
   logic [1:0]         state_r;
   logic [1:0]         state_nxt_s;
   logic [CW-1:0]      cnt_r;
   logic [CW-1:0]      cnt_nxt_s;
   logic               err_enter_s;
   logic               force_hunt_s;
   logic               pop_s;
   logic               all_next_s;
   logic               any_next_s;

   // Lock status as it will be after this edge: lets the FSM leave IDLE on
   // the same edge a lane locks, so a single-lane link goes straight to RUN.
   assign all_next_s   = &(locked_s | hit_s);
   assign any_next_s   = |(locked_s | hit_s);
   assign force_hunt_s = err_enter_s || (state_r == TOP_ERR);
   assign pop_s        = (state_r == TOP_RUN) && hs_active && !(|empty_s);
   assign lane_locked  = locked_s;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      mipi_lane_aligner #(
         .SYNC  (SYNC_BYTE),
         .DEPTH (DEPTH)
      ) u_lane (
         .gclk       (gclk),
         .rst        (rst),
         .hs_active  (hs_active),
         .force_hunt (force_hunt_s),
         .pop        (pop_s),
         .din        (din[i*8 +: 8]),
         .hit        (hit_s[i]),
         .locked     (locked_s[i]),
         .fifo_empty (empty_s[i]),
         .data       (word_s[i*8 +: 8])
      );
   end

   // Top FSM next state and skew counter; burst end outranks everything.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      err_enter_s = 1'b0;
      case (state_r)
         TOP_IDLE: begin
            if (!hs_active) begin
               state_nxt_s = TOP_IDLE;
            end else if (all_next_s) begin
               state_nxt_s = TOP_RUN;
            end else if (any_next_s) begin
               state_nxt_s = TOP_WAIT;
               cnt_nxt_s   = {CW{1'b0}};
            end else begin
               state_nxt_s = TOP_IDLE;
            end
         end
         TOP_WAIT: begin
            if (!hs_active) begin
               state_nxt_s = TOP_IDLE;
            end else if (all_next_s) begin
               state_nxt_s = TOP_RUN;
            end else if (cnt_r == CW'(MAX_SKEW - 1)) begin
               // Counter would reach MAX_SKEW with a lane still hunting.
               state_nxt_s = TOP_ERR;
               err_enter_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + 1'b1;
            end
         end
         TOP_RUN: begin
            if (!hs_active) begin
               state_nxt_s = TOP_IDLE;
            end else begin
               state_nxt_s = TOP_RUN;
            end
         end
         TOP_ERR: begin
            // Hold off re-hunting until the burst has ended.
            if (!hs_active) begin
               state_nxt_s = TOP_IDLE;
            end else begin
               state_nxt_s = TOP_ERR;
            end
         end
         default: begin
            state_nxt_s = TOP_IDLE;
            cnt_nxt_s   = {CW{1'b0}};
         end
      endcase
   end

   // Top FSM state and skew counter registers.
   always_ff @(posedge gclk) begin
      if (rst) begin
         state_r <= TOP_IDLE;
         cnt_r   <= {CW{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Registered outputs: word appears the cycle after the common pop.
   always_ff @(posedge gclk) begin
      if (rst) begin
         dout       <= {(LANES*8){1'b0}};
         dout_valid <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         dout_valid <= pop_s;
         sync_err   <= err_enter_s;
         if (pop_s) begin
            dout <= word_s;
         end else begin
            dout <= dout;
         end
      end
   end

endmodule

// File: tb/tb_mipi_byte_aligner.sv
// -----------------------------------------------------------------------------
// tb_mipi_byte_aligner
// Directed bench: builds per-lane bitstreams (optional delay and bit shift),
// drives them one byte per cycle and compares outputs against values derived
// from the stream construction.
// -----------------------------------------------------------------------------
module tb_mipi_byte_aligner;

   logic        gclk = 1'b0;
   logic        rst;
   logic        hs_active;
   logic [31:0] din;
   logic [31:0] dout;
   logic        dout_valid;
   logic [3:0]  lane_locked;
   logic        sync_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [255:0] vec [4];
   int           dly [4];
   logic         fd  [4];

   always #5 gclk = ~gclk;

   mipi_byte_aligner #(
      .LANES     (4),
      .SYNC_BYTE (8'hB8),
      .MAX_SKEW  (3)
   ) dut (
      .gclk        (gclk),
      .rst         (rst),
      .hs_active   (hs_active),
      .din         (din),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .lane_locked (lane_locked),
      .sync_err    (sync_err)
   );

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Payload byte i; the "false data" variant carries sync bytes.
   function automatic logic [7:0] pay(input int i, input logic f);
      if (f) begin
         case (i)
            0:       return 8'hB8;
            1:       return 8'h5C;
            2:       return 8'hB8;
            3:       return 8'h70;
            default: return 8'h00;
         endcase
      end
      return 8'(8'h11 * (i + 1));
   endfunction

   // Lane stream: (1+d) leading zero bytes, sync, 12 payload bytes, then
   // shifted later on the line by s bits.
   task automatic load_lane(input int l, input int d, input int s, input logic f);
      vec[l] = '0;
      dly[l] = d;
      fd[l]  = f;
      vec[l][(1 + d) * 8 +: 8] = 8'hB8;
      for (int i = 0; i < 12; i++) vec[l][(2 + d + i) * 8 +: 8] = pay(i, f);
      vec[l] = vec[l] << s;
   endtask

   task automatic set_din(input int j);
      for (int l = 0; l < 4; l++) din[l*8 +: 8] = vec[l][j*8 +: 8];
   endtask

   task automatic tick;
      @(posedge gclk);
      #1;
   endtask

   // Lock after edge 2+d, first valid word two edges after the last lock.
   task automatic run_burst(input int ncyc, input bit end_burst);
      int          fv;
      logic [3:0]  el;
      logic [31:0] ew;
      fv = 0;
      for (int l = 0; l < 4; l++) if (dly[l] + 4 > fv) fv = dly[l] + 4;
      hs_active = 1'b1;
      set_din(0);
      for (int j = 0; j < ncyc; j++) begin
         tick;
         for (int l = 0; l < 4; l++) el[l] = (j >= 2 + dly[l]);
         check_val("lane_locked", {28'd0, lane_locked}, {28'd0, el});
         check_val("sync_err", {31'd0, sync_err}, 32'd0);
         if (j >= fv) begin
            for (int l = 0; l < 4; l++) ew[l*8 +: 8] = pay(j - fv, fd[l]);
            check_val("dout_valid", {31'd0, dout_valid}, 32'd1);
            check_val("dout", dout, ew);
         end else begin
            check_val("dout_valid_early", {31'd0, dout_valid}, 32'd0);
         end
         set_din(j + 1);
      end
      if (end_burst) begin
         hs_active = 1'b0;
         din       = 32'd0;
         tick;
         check_val("end_valid", {31'd0, dout_valid}, 32'd0);
         check_val("end_locked", {28'd0, lane_locked}, 32'd0);
         tick;
      end
   endtask

   initial begin
      rst       = 1'b1;
      hs_active = 1'b0;
      din       = 32'd0;
      tick; tick; tick;
      check_val("rst_dout", dout, 32'd0);
      check_val("rst_valid", {31'd0, dout_valid}, 32'd0);
      check_val("rst_locked", {28'd0, lane_locked}, 32'd0);
      check_val("rst_sync_err", {31'd0, sync_err}, 32'd0);
      rst = 1'b0;
      tick;

      // Zero offset on all lanes.
      for (int l = 0; l < 4; l++) load_lane(l, 0, 0, 1'b0);
      run_burst(10, 1'b1);

      // Lane 0 shifted by 3 bits.
      load_lane(0, 0, 3, 1'b0);
      for (int l = 1; l < 4; l++) load_lane(l, 0, 0, 1'b0);
      run_burst(10, 1'b1);

      // Lane 2 syncs two cycles late, inside the skew window.
      for (int l = 0; l < 4; l++) load_lane(l, (l == 2) ? 2 : 0, 0, 1'b0);
      run_burst(10, 1'b1);

      // Payload containing sync bytes after lock, mixed offsets.
      load_lane(0, 0, 5, 1'b1);
      load_lane(1, 0, 0, 1'b1);
      load_lane(2, 0, 0, 1'b0);
      load_lane(3, 0, 7, 1'b0);
      run_burst(10, 1'b1);

      // Skew timeout: lane 3 silent; later syncs in the same burst ignored.
      for (int l = 0; l < 3; l++) begin
         load_lane(l, 0, 0, 1'b0);
         vec[l][8*8 +: 8] = 8'hB8;
         vec[l][9*8 +: 8] = 8'h11;
      end
      vec[3] = '0;
      vec[3][8*8 +: 8] = 8'hB8;
      vec[3][9*8 +: 8] = 8'h11;
      dly[3] = 0;
      fd[3]  = 1'b0;
      hs_active = 1'b1;
      set_din(0);
      for (int j = 0; j < 13; j++) begin
         tick;
         check_val("to_sync_err", {31'd0, sync_err}, (j == 5) ? 32'd1 : 32'd0);
         check_val("to_locked", {28'd0, lane_locked},
                   (j >= 2 && j <= 4) ? 32'h7 : 32'h0);
         check_val("to_valid", {31'd0, dout_valid}, 32'd0);
         set_din(j + 1);
      end
      hs_active = 1'b0;
      din       = 32'd0;
      tick;
      check_val("to_end_locked", {28'd0, lane_locked}, 32'd0);
      check_val("to_end_sync_err", {31'd0, sync_err}, 32'd0);
      tick;
      for (int l = 0; l < 4; l++) load_lane(l, 0, 0, 1'b0);
      run_burst(10, 1'b1);

      // Reset in the middle of RUN, then relock within the same burst.
      run_burst(7, 1'b0);
      rst = 1'b1;
      tick;
      check_val("mid_rst_dout", dout, 32'd0);
      check_val("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
      check_val("mid_rst_locked", {28'd0, lane_locked}, 32'd0);
      check_val("mid_rst_sync_err", {31'd0, sync_err}, 32'd0);
      rst = 1'b0;
      run_burst(10, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
